sprite_linebuf_scan: RTL and testbench

SPRITE_LINEBUF_SCAN -- requirements
Module: sprite_linebuf_scan

---
 rtl/sprite_linebuf_scan_pkg.sv | 7 +
 rtl/sprite_linebuf_scan_bank.sv | 18 +
 rtl/sprite_linebuf_scan.sv | 71 +++++++
 tb/tb_sprite_linebuf_scan.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sprite_linebuf_scan_pkg.sv
// sprite_linebuf_scan_pkg: shared line-buffer sizes, transparent pen code and reader FSM states
package sprite_linebuf_scan_pkg;
  localparam int LB_AW = 9;
  localparam int LB_DEPTH = 512;
  localparam logic [3:0] PEN_TRANSPARENT = 4'h0;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_OUT, ST_CLEAR} rd_state_t;
endpackage

// File: rtl/sprite_linebuf_scan_bank.sv
// linebuf_bank: 512x8 single-clock RAM; ports clk, write (i_we/i_waddr/i_wdata), sync read (i_re/i_raddr -> o_rdata)
module linebuf_bank
  import sprite_linebuf_scan_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic [LB_AW-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic             i_re,
  input  logic [LB_AW-1:0] i_raddr,
  output logic [7:0]       o_rdata
);
  logic [7:0] r_mem [LB_DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sprite_linebuf_scan.sv
// sprite_linebuf_scan: double-banked sprite line buffer; writer port (wr_*), scan readout (pixel_ce/hpix/hblank/screen_flip -> pixel_output/pixel_valid), bank swap on line_start
module sprite_linebuf_scan
  import sprite_linebuf_scan_pkg::*;
(
  input  logic             master_clk,
  input  logic             reset,
  input  logic             pixel_ce,
  input  logic             line_start,
  input  logic [LB_AW-1:0] hpix,
  input  logic             hblank,
  input  logic             screen_flip,
  input  logic             wr_en,
  input  logic [LB_AW-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  output logic [7:0]       pixel_output,
  output logic             pixel_valid,
  output logic             wr_bank
);
  rd_state_t        r_state, w_next;
  logic             r_wr_bank, r_rbank, r_valid;
  logic [LB_AW-1:0] r_addr, w_raddr;
  logic [7:0]       r_pix, w_rd;
  logic [7:0]       w_rdata [2];
  logic             w_go, w_blank, w_wr, w_clr;
  assign w_raddr = screen_flip ? ~hpix : hpix;
  assign w_go    = !reset && r_state == ST_IDLE && pixel_ce && !hblank;
  assign w_blank = r_state == ST_IDLE && pixel_ce && hblank;
  assign w_wr    = !reset && wr_en && wr_data[7:4] != PEN_TRANSPARENT;
  assign w_clr   = !reset && r_state == ST_CLEAR;
  assign w_rd    = w_rdata[r_rbank];
  always_comb
    w_next = r_state == ST_IDLE ? (w_go ? ST_READ : ST_IDLE) :
             r_state == ST_READ ? ST_OUT :
             r_state == ST_OUT  ? ST_CLEAR : ST_IDLE;
  always_ff @(posedge master_clk) begin
    if (reset) begin
      r_wr_bank <= 1'b0;
      r_state   <= ST_IDLE;
      r_pix     <= 8'h00;
      r_valid   <= 1'b0;
    end else begin
      r_wr_bank <= r_wr_bank ^ line_start;
      r_state   <= w_next;
      r_valid   <= r_state == ST_READ;
      r_pix     <= r_state == ST_READ ? {w_rd[3:0], w_rd[7:4]} : w_blank ? 8'h00 : r_pix;
      if (w_go) begin
        r_addr  <= w_raddr;
        r_rbank <= ~r_wr_bank;
      end
    end
  end
  // The RAM is read in the IDLE cycle that accepts pixel_ce so the pixel lands two clocks later;
  // a clear that collides with a renderer write on the same bank yields to the renderer.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic w_wsel, w_csel;
    assign w_wsel = w_wr && r_wr_bank == 1'(b);
    assign w_csel = w_clr && r_rbank == 1'(b) && !w_wsel;
    linebuf_bank u_bank (
      .clk     (master_clk),
      .i_we    (w_wsel || w_csel),
      .i_waddr (w_wsel ? wr_addr : r_addr),
      .i_wdata (w_wsel ? wr_data : 8'h00),
      .i_re    (w_go && r_wr_bank != 1'(b)),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata[b])
    );
  end
  assign pixel_output = r_pix;
  assign pixel_valid  = r_valid;
  assign wr_bank      = r_wr_bank;
endmodule

// File: tb/tb_sprite_linebuf_scan.sv
// tb_sprite_linebuf_scan: table-driven and directed checks of the sprite line buffer
module tb_sprite_linebuf_scan;
  logic       master_clk = 1'b0;
  logic       reset = 1'b1, pixel_ce = 1'b0, line_start = 1'b0, hblank = 1'b0, screen_flip = 1'b0, wr_en = 1'b0;
  logic [8:0] hpix = '0, wr_addr = '0;
  logic [7:0] wr_data = '0, pixel_output;
  logic       pixel_valid, wr_bank;
  int         n_pass = 0, n_total = 0;
  logic       exp_bank = 1'b0;
  logic [7:0] pix;
  logic       v, v1;
  typedef struct {
    logic [8:0] waddr;
    logic [7:0] wdata;
    logic       flip;
    logic [8:0] hpix;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [8];
  sprite_linebuf_scan dut (
    .master_clk   (master_clk),
    .reset        (reset),
    .pixel_ce     (pixel_ce),
    .line_start   (line_start),
    .hpix         (hpix),
    .hblank       (hblank),
    .screen_flip  (screen_flip),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pixel_output (pixel_output),
    .pixel_valid  (pixel_valid),
    .wr_bank      (wr_bank)
  );
  always #5 master_clk = ~master_clk;
  task automatic tick();
    @(posedge master_clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic swap();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    exp_bank = ~exp_bank;
    chk("wr_bank_swap", wr_bank, exp_bank);
  endtask
  task automatic rd(input logic [8:0] h, input logic f, output logic [7:0] p, output logic pv, output logic pv1);
    hpix = h; screen_flip = f; hblank = 1'b0; pixel_ce = 1'b1;
    tick();
    pixel_ce = 1'b0;
    pv1 = pixel_valid;
    tick();
    p = pixel_output; pv = pixel_valid;
    tick();
    tick();
  endtask
  initial begin
    vecs[0] = '{9'h010, 8'h5A, 1'b0, 9'h010, 8'hA5};
    vecs[1] = '{9'h020, 8'h0F, 1'b0, 9'h020, 8'h00};
    vecs[2] = '{9'h1FF, 8'h31, 1'b1, 9'h000, 8'h13};
    vecs[3] = '{9'h000, 8'hC3, 1'b0, 9'h000, 8'h3C};
    vecs[4] = '{9'h1FF, 8'hFF, 1'b0, 9'h1FF, 8'hFF};
    vecs[5] = '{9'h0AB, 8'h12, 1'b1, 9'h154, 8'h21};
    vecs[6] = '{9'h100, 8'h80, 1'b0, 9'h100, 8'h08};
    vecs[7] = '{9'h055, 8'hE7, 1'b1, 9'h1AA, 8'h7E};
    tick(); tick();
    chk("reset_pix", pixel_output, 8'h00);
    chk("reset_valid", pixel_valid, 1'b0);
    chk("reset_bank", wr_bank, 1'b0);
    reset = 1'b0;
    // every readout clears its word, so sweeping both banks leaves them all zero
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 512; a++) rd(9'(a), 1'b0, pix, v, v1);
      swap();
    end
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      swap();
      rd(vecs[i].hpix, vecs[i].flip, pix, v, v1);
      chk($sformatf("vec%0d_pix", i), pix, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), v, 1'b1);
      chk($sformatf("vec%0d_latency", i), v1, 1'b0);
    end
    wr(9'h010, 8'h5A); swap();
    rd(9'h010, 1'b0, pix, v, v1);
    chk("reread_first", pix, 8'hA5);
    swap(); swap();
    rd(9'h010, 1'b0, pix, v, v1);
    chk("reread_cleared", pix, 8'h00);
    wr(9'h005, 8'h40); wr(9'h005, 8'h70); swap();
    rd(9'h005, 1'b0, pix, v, v1);
    chk("last_writer", pix, 8'h07);
    line_start = 1'b1; wr_en = 1'b1; wr_addr = 9'h008; wr_data = 8'h22;
    tick();
    line_start = 1'b0; wr_en = 1'b0; exp_bank = ~exp_bank;
    chk("same_cycle_bank", wr_bank, exp_bank);
    rd(9'h008, 1'b0, pix, v, v1);
    chk("same_cycle_pre_bank", pix, 8'h22);
    swap();
    rd(9'h008, 1'b0, pix, v, v1);
    chk("same_cycle_other_bank", pix, 8'h00);
    swap();
    rd(9'h008, 1'b0, pix, v, v1);
    chk("same_cycle_cleared", pix, 8'h00);
    wr(9'h040, 8'h5B); wr(9'h041, 8'h66); swap();
    hpix = 9'h040; screen_flip = 1'b0; pixel_ce = 1'b1;
    tick();
    hpix = 9'h041;
    tick();
    pixel_ce = 1'b0;
    chk("busy_ce_pix", pixel_output, 8'hB5);
    chk("busy_ce_valid", pixel_valid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("busy_ce_no_queue%0d", k), pixel_valid, 1'b0);
    end
    wr(9'h070, 8'hD4); swap();
    hpix = 9'h070; hblank = 1'b1; pixel_ce = 1'b1;
    tick();
    pixel_ce = 1'b0; hblank = 1'b0;
    chk("hblank_pix", pixel_output, 8'h00);
    chk("hblank_valid", pixel_valid, 1'b0);
    tick();
    chk("hblank_valid_late", pixel_valid, 1'b0);
    tick(); tick();
    rd(9'h070, 1'b0, pix, v, v1);
    chk("hblank_no_access", pix, 8'h4D);
    wr(9'h060, 8'hC9); swap();
    hpix = 9'h060; pixel_ce = 1'b1;
    tick();
    pixel_ce = 1'b0; line_start = 1'b1;
    tick();
    line_start = 1'b0; exp_bank = ~exp_bank;
    chk("midseq_bank", wr_bank, exp_bank);
    chk("midseq_pix", pixel_output, 8'h9C);
    chk("midseq_valid", pixel_valid, 1'b1);
    tick(); tick();
    swap();
    rd(9'h060, 1'b0, pix, v, v1);
    chk("midseq_cleared_latched", pix, 8'h00);
    if (exp_bank == 1'b0) swap();
    wr(9'h030, 8'h96); swap();
    hpix = 9'h030; pixel_ce = 1'b1;
    tick();
    pixel_ce = 1'b0;
    tick();
    chk("rstclr_pix", pixel_output, 8'h69);
    tick();
    reset = 1'b1; line_start = 1'b1; pixel_ce = 1'b1; wr_en = 1'b1; wr_addr = 9'h031; wr_data = 8'h11;
    tick();
    reset = 1'b0; line_start = 1'b0; pixel_ce = 1'b0; wr_en = 1'b0; exp_bank = 1'b0;
    chk("rstclr_pix_zero", pixel_output, 8'h00);
    chk("rstclr_valid", pixel_valid, 1'b0);
    chk("rstclr_bank", wr_bank, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rstclr_no_valid%0d", k), pixel_valid, 1'b0);
    end
    rd(9'h030, 1'b0, pix, v, v1);
    chk("rstclr_retained", pix, 8'h69);
    swap();
    rd(9'h031, 1'b0, pix, v, v1);
    chk("rst_blocks_write", pix, 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
